backbone_to_vinput: RTL and testbench
=====================================

# backbone_to_vinput

Computes a leave-one-out variable-node input in IEEE-754 binary64. The block subtracts one selected alpha term from a precomputed backbone sum: vinput = backbone − alpha_u[ind_j][x_initial[ind_j]]. It sits after the backbone accumulator and feeds the vinput stage of the iterative detector. All four operands arrive on independent valid strobes, and one result is emitted per complete operand set.

## Interface
- J, 14: number of resources (rows of alpha_u).
- I, 7: number of users; carried for codebase consistency and not used in the datapath.
- A, 2: alphabet size (columns per row of alpha_u).
- Derived: J_WIDTH = $clog2(J)+1; A_WIDTH = $clog2(A)+1.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- backbone, input, 64: binary64 backbone sum.
- backbone_tvalid, input, 1: capture strobe for backbone.
- x_initial, input, J*A_WIDTH: entry j is at bits [j*A_WIDTH +: A_WIDTH], unsigned symbol index.
- x_initial_tvalid, input, 1: capture strobe for x_initial.
- ind_j, input, J_WIDTH: 0-based row to exclude.
- ind_j_tvalid, input, 1: capture strobe for ind_j.
- alpha_u, input, J*A*64: element (j,a) is at bits [(j*A+a)*64 +: 64], binary64.
- alpha_u_tvalid, input, 1: capture strobe for alpha_u.
- vinput_tvalid, output, 1: one-cycle result strobe.
- vinput, output, 64: binary64 result, held until the next result.

## Operation
- Each operand has a shadow register and a "have" flag.
  - A high tvalid at a clock edge overwrites that register and sets its flag.
  - Strobes may come in any cycle and in any order.
- FSM states: IDLE → SEL → ALIGN → ADD → OUT → IDLE.
- IDLE: when all four flags are set, snapshot the operands, clear the flags, and go to SEL.
  - If a tvalid is high in that same cycle, the new capture wins: its flag ends set and belongs to the next job.
- SEL: term = alpha_u[ind_j][x_initial[ind_j]].
  - If ind_j ≥ J or x_initial[ind_j] ≥ A, term = +0.0 and the result is backbone (after flush rules).
- ALIGN: compute the effective operation on backbone and −term. Swap so the larger magnitude comes first. Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits. A shift ≥ 56 becomes sticky only.
- ADD: add or subtract the 56-bit extended significands.
- OUT: normalize (leading-zero count, left shift, or 1-bit right shift on carry). Round to nearest, ties to even; handle the rounding carry. Register vinput and pulse vinput_tvalid.
- Arithmetic rules:
  - Subnormal inputs are treated as ±0. Subnormal results flush to +0.0.
  - An exact-zero result is +0.0.
  - Exponent overflow gives ±Inf.
  - Any NaN input, or +Inf − (+Inf), gives 0x7FF8000000000000.
  - Inf with a finite operand gives that Inf with the correct sign.
- Strobes arriving while the FSM is busy are captured for the next job. At most one job is in flight.

## Timing
- Reset values: vinput = 0, vinput_tvalid = 0, all flags clear, FSM in IDLE.
- Reset mid-operation aborts the job. No vinput_tvalid is produced for it.
- Latency: edge E0 captures the last missing operand. vinput_tvalid is high for exactly one cycle following edge E0+4.
- vinput becomes valid in the same cycle as vinput_tvalid and stays stable until the next OUT.
- Throughput: one result per 5 cycles when operands are re-strobed continuously.
- There is no backpressure. The consumer must take vinput while vinput_tvalid is high.

## Test plan
- All four strobes in one cycle with the following values -> one vinput_tvalid pulse 4 cycles later with vinput = 0xC028000000000000 (−12.0).
  - backbone = 1.0.
  - ind_j = 7.
  - x_initial entries alternating 0,1,0,1… (entry 7 = 1).
  - alpha_u element at flat index k = 28.0 − k, so (7,1) = 13.0.
- Operands strobed on four different cycles in scrambled order -> result timed from the last strobe and equal to the one-cycle case. No output appears before all four are captured.
- backbone = 13.0 and selected term = 13.0 -> vinput = 0x0000000000000000. Separately, backbone = 0x3FF0000000000001 and term = 1.0 -> exact tiny result with correct normalization.
- Out-of-range selection (ind_j = J, or x_initial entry = 3 with A = 2) -> vinput = backbone.
- Special values: NaN backbone -> 0x7FF8000000000000. +Inf − +Inf -> 0x7FF8000000000000. Inf − 1.0 -> Inf. A rounding tie case -> result rounds to even.
- Reset asserted two cycles after launch -> no vinput_tvalid. vinput reads 0. A fresh operand set afterwards produces a correct result.

Source files
------------

// File: rtl/backbone_to_vinput_if.sv
// Operand/result bundle for backbone_to_vinput: four independently strobed
// operands in, one strobed binary64 result out.
interface backbone_to_vinput_if #(
    parameter int J       = 14,
    parameter int A       = 2,
    parameter int J_WIDTH = $clog2(J) + 1,
    parameter int A_WIDTH = $clog2(A) + 1
);
    logic [63:0]          backbone;
    logic                 backbone_tvalid;
    logic [J*A_WIDTH-1:0] x_initial;
    logic                 x_initial_tvalid;
    logic [J_WIDTH-1:0]   ind_j;
    logic                 ind_j_tvalid;
    logic [J*A*64-1:0]    alpha_u;
    logic                 alpha_u_tvalid;
    logic                 vinput_tvalid;
    logic [63:0]          vinput;

    modport master (
        output backbone, backbone_tvalid, x_initial, x_initial_tvalid,
               ind_j, ind_j_tvalid, alpha_u, alpha_u_tvalid,
        input  vinput_tvalid, vinput
    );

    modport slave (
        input  backbone, backbone_tvalid, x_initial, x_initial_tvalid,
               ind_j, ind_j_tvalid, alpha_u, alpha_u_tvalid,
        output vinput_tvalid, vinput
    );
endinterface

// File: rtl/backbone_to_vinput.sv
// Leave-one-out variable-node input: vinput = backbone - alpha_u[ind_j][x_initial[ind_j]]
// in binary64 with flush-to-zero, RNE rounding and a canonical quiet NaN.
module backbone_to_vinput #(
    parameter int J = 14,
    parameter int I = 7,
    parameter int A = 2,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int A_WIDTH = $clog2(A) + 1
) (
    input logic                 clk,
    input logic                 rst,
    backbone_to_vinput_if.slave bus
);
    if (I < 1 || J < 1 || A < 1) begin : g_param_check
        $error("backbone_to_vinput: J, I and A must all be positive");
    end

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {IDLE, SEL, ALIGN, ADD, OUT} state_t;

    state_t               state_q, state_d;
    logic                 have_bb_q, have_bb_d, have_xi_q, have_xi_d;
    logic                 have_ind_q, have_ind_d, have_al_q, have_al_d;
    logic                 launch;
    logic [63:0]          bb_sh_q, bb_sh_d;
    logic [J*A_WIDTH-1:0] xi_sh_q, xi_sh_d;
    logic [J_WIDTH-1:0]   ind_sh_q, ind_sh_d;
    logic [J*A*64-1:0]    al_sh_q, al_sh_d;
    logic [63:0]          sel_term;
    logic [63:0]          sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic                 aln_spec_q, aln_spec_d, aln_sign_q, aln_sign_d, aln_sub_q, aln_sub_d;
    logic [63:0]          aln_spec_val_q, aln_spec_val_d;
    logic [10:0]          aln_exp_q, aln_exp_d;
    logic [55:0]          aln_x_q, aln_x_d, aln_y_q, aln_y_d;
    logic                 add_spec_q, add_spec_d, add_sign_q, add_sign_d;
    logic [63:0]          add_spec_val_q, add_spec_val_d;
    logic [10:0]          add_exp_q, add_exp_d;
    logic [56:0]          add_sum_q, add_sum_d;
    logic [63:0]          vinput_q, vinput_d;
    logic                 vinput_tvalid_q, vinput_tvalid_d;

    logic [10:0]          ea, eb, ey, dexp;
    logic [51:0]          fa, fb;
    logic                 sa, sb, a_nan, b_nan, a_inf, b_inf, swap, lost;
    logic [62:0]          ka, kb;
    logic [55:0]          ma, mb, my, shifted;
    logic [5:0]           lz;
    logic [55:0]          norm_m;
    logic signed [12:0]   norm_e;
    logic [63:0]          result;

    function automatic logic [5:0] lzc56(input logic [55:0] v);
        lzc56 = 6'd56;
        for (int i = 0; i < 56; i++) begin
            if (v[i]) lzc56 = 6'(55 - i);
        end
    endfunction

    // m has its leading one at bit 55; bits [2:0] are guard, round, sticky.
    function automatic logic [63:0] round_pack(input logic sign, input logic signed [12:0] e,
                                               input logic [55:0] m);
        logic              up;
        logic [53:0]       mr;
        logic signed [12:0] er;
        up = m[2] & (m[1] | m[0] | m[3]);
        mr = {1'b0, m[55:3]} + {53'd0, up};
        er = mr[53] ? e + 13'sd1 : e;
        if (e <= 13'sd0)
            round_pack = 64'd0;
        else if (er >= 13'sd2047)
            round_pack = {sign, 11'h7FF, 52'd0};
        else
            round_pack = {sign, er[10:0], mr[51:0]};
    endfunction

    // Operand capture and job launch
    always_comb begin
        launch     = (state_q == IDLE) && have_bb_q && have_xi_q && have_ind_q && have_al_q;
        have_bb_d  = bus.backbone_tvalid  | (have_bb_q  & ~launch);
        have_xi_d  = bus.x_initial_tvalid | (have_xi_q  & ~launch);
        have_ind_d = bus.ind_j_tvalid     | (have_ind_q & ~launch);
        have_al_d  = bus.alpha_u_tvalid   | (have_al_q  & ~launch);
        bb_sh_d    = bus.backbone_tvalid  ? bus.backbone  : bb_sh_q;
        xi_sh_d    = bus.x_initial_tvalid ? bus.x_initial : xi_sh_q;
        ind_sh_d   = bus.ind_j_tvalid     ? bus.ind_j     : ind_sh_q;
        al_sh_d    = bus.alpha_u_tvalid   ? bus.alpha_u   : al_sh_q;
        sel_a_d    = launch ? bb_sh_q  : sel_a_q;
        sel_b_d    = launch ? sel_term : sel_b_q;
        state_d         = state_q;
        vinput_d        = vinput_q;
        vinput_tvalid_d = 1'b0;
        case (state_q)
            IDLE:    if (launch) state_d = SEL;
            SEL:     state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD: begin
                state_d         = OUT;
                vinput_d        = result;
                vinput_tvalid_d = 1'b1;
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range row or symbol leaves term at +0.0
    always_comb begin
        sel_term = 64'd0;
        for (int j = 0; j < J; j++) begin
            for (int a = 0; a < A; a++) begin
                if (ind_sh_q == J_WIDTH'(j) && xi_sh_q[j*A_WIDTH +: A_WIDTH] == A_WIDTH'(a))
                    sel_term = al_sh_q[(j*A+a)*64 +: 64];
            end
        end
    end

    // ALIGN stage: classify, order by magnitude, shift the smaller operand
    always_comb begin
        ea = sel_a_q[62:52];  fa = sel_a_q[51:0];  sa = sel_a_q[63];
        eb = sel_b_q[62:52];  fb = sel_b_q[51:0];  sb = ~sel_b_q[63];
        a_nan = (ea == 11'h7FF) && (fa != 52'd0);
        b_nan = (eb == 11'h7FF) && (fb != 52'd0);
        a_inf = (ea == 11'h7FF) && (fa == 52'd0);
        b_inf = (eb == 11'h7FF) && (fb == 52'd0);
        ka = (ea == 11'd0) ? 63'd0 : sel_a_q[62:0];
        kb = (eb == 11'd0) ? 63'd0 : sel_b_q[62:0];
        ma = (ea == 11'd0) ? 56'd0 : {1'b1, fa, 3'b000};
        mb = (eb == 11'd0) ? 56'd0 : {1'b1, fb, 3'b000};
        swap       = kb > ka;
        aln_sign_d = swap ? sb : sa;
        aln_exp_d  = swap ? eb : ea;
        aln_x_d    = swap ? mb : ma;
        my         = swap ? ma : mb;
        ey         = swap ? ea : eb;
        aln_sub_d  = sa ^ sb;
        dexp       = aln_exp_d - ey;
        shifted    = my >> dexp[5:0];
        lost       = |(my & ~({56{1'b1}} << dexp[5:0]));
        if (dexp >= 11'd56)
            aln_y_d = {55'd0, |my};
        else
            aln_y_d = {shifted[55:1], shifted[0] | lost};
        aln_spec_d = 1'b1;
        if (a_nan || b_nan)
            aln_spec_val_d = QNAN;
        else if (a_inf && b_inf)
            aln_spec_val_d = (sa != sb) ? QNAN : {sa, 11'h7FF, 52'd0};
        else if (a_inf)
            aln_spec_val_d = {sa, 11'h7FF, 52'd0};
        else if (b_inf)
            aln_spec_val_d = {sb, 11'h7FF, 52'd0};
        else begin
            aln_spec_d     = 1'b0;
            aln_spec_val_d = 64'd0;
        end
    end

    // ADD stage
    always_comb begin
        add_sum_d      = aln_sub_q ? ({1'b0, aln_x_q} - {1'b0, aln_y_q})
                                   : ({1'b0, aln_x_q} + {1'b0, aln_y_q});
        add_spec_d     = aln_spec_q;
        add_spec_val_d = aln_spec_val_q;
        add_sign_d     = aln_sign_q;
        add_exp_d      = aln_exp_q;
    end

    // OUT stage: normalize, then round and pack
    always_comb begin
        lz = lzc56(add_sum_q[55:0]);
        if (add_sum_q[56]) begin
            norm_m = {add_sum_q[56:2], add_sum_q[1] | add_sum_q[0]};
            norm_e = $signed({2'b00, add_exp_q}) + 13'sd1;
        end else begin
            norm_m = add_sum_q[55:0] << lz;
            norm_e = $signed({2'b00, add_exp_q}) - $signed({7'd0, lz});
        end
        if (add_spec_q)
            result = add_spec_val_q;
        else if (add_sum_q == 57'd0)
            result = 64'd0;
        else
            result = round_pack(add_sign_q, norm_e, norm_m);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            have_bb_q       <= 1'b0;
            have_xi_q       <= 1'b0;
            have_ind_q      <= 1'b0;
            have_al_q       <= 1'b0;
            vinput_q        <= 64'd0;
            vinput_tvalid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            have_bb_q       <= have_bb_d;
            have_xi_q       <= have_xi_d;
            have_ind_q      <= have_ind_d;
            have_al_q       <= have_al_d;
            vinput_q        <= vinput_d;
            vinput_tvalid_q <= vinput_tvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        bb_sh_q        <= bb_sh_d;
        xi_sh_q        <= xi_sh_d;
        ind_sh_q       <= ind_sh_d;
        al_sh_q        <= al_sh_d;
        sel_a_q        <= sel_a_d;
        sel_b_q        <= sel_b_d;
        aln_spec_q     <= aln_spec_d;
        aln_spec_val_q <= aln_spec_val_d;
        aln_sign_q     <= aln_sign_d;
        aln_sub_q      <= aln_sub_d;
        aln_exp_q      <= aln_exp_d;
        aln_x_q        <= aln_x_d;
        aln_y_q        <= aln_y_d;
        add_spec_q     <= add_spec_d;
        add_spec_val_q <= add_spec_val_d;
        add_sign_q     <= add_sign_d;
        add_exp_q      <= add_exp_d;
        add_sum_q      <= add_sum_d;
    end

    assign bus.vinput        = vinput_q;
    assign bus.vinput_tvalid = vinput_tvalid_q;
endmodule

// File: tb/tb_backbone_to_vinput.sv
// Bench for backbone_to_vinput: fixed vectors, multi-cycle corner sequences and
// random jobs scored against a real-arithmetic reference.
module tb_backbone_to_vinput;
    localparam int J  = 14;
    localparam int A  = 2;
    localparam int AW = 2;
    localparam int JW = 5;
    localparam int NV = 14;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    backbone_to_vinput_if bus ();
    backbone_to_vinput dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0]   bb;
        logic [JW-1:0] ind;
        logic [AW-1:0] xsel;
        logic [63:0]   term;
        logic [63:0]   expv;
    } vec_t;
    vec_t vecs[NV];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic logic [J*A*64-1:0] pattern_alpha();
        logic [J*A*64-1:0] v;
        for (int k = 0; k < J*A; k++) v[k*64 +: 64] = $realtobits(28.0 - real'(k));
        return v;
    endfunction

    function automatic logic [J*AW-1:0] pattern_xi();
        logic [J*AW-1:0] v;
        for (int j = 0; j < J; j++) v[j*AW +: AW] = AW'(j % 2);
        return v;
    endfunction

    // Reference: ordinary double subtraction with the block's flush/NaN rules
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] t);
        real ra, rt;
        logic [63:0] r;
        ra = (a[62:52] == 11'd0) ? 0.0 : $bitstoreal(a);
        rt = (t[62:52] == 11'd0) ? 0.0 : $bitstoreal(t);
        r  = $realtobits(ra - rt);
        if (r[62:52] == 11'h7FF && r[51:0] != 52'd0) return QNAN;
        if (r[62:52] == 11'd0) return 64'd0;
        return r;
    endfunction

    function automatic logic [63:0] rand_double(input logic [10:0] near);
        logic [63:0] v;
        int c, e;
        v = {$urandom, $urandom};
        c = int'($urandom_range(0, 19));
        e = int'(near) + int'($urandom_range(0, 8)) - 4;
        if (e < 1) e = 1;
        if (e > 2046) e = 2046;
        case (c)
            0:       begin v[62:52] = 11'h7FF; v[0] = 1'b1; end
            1:       v[62:0] = {11'h7FF, 52'd0};
            2:       v[62:0] = 63'd0;
            3:       v[62:52] = 11'd0;
            4:       v[62:52] = 11'(2040 + int'($urandom_range(0, 6)));
            default: v[62:52] = 11'(e);
        endcase
        return v;
    endfunction

    task automatic set_tvalids(input logic v);
        bus.backbone_tvalid  = v;
        bus.x_initial_tvalid = v;
        bus.ind_j_tvalid     = v;
        bus.alpha_u_tvalid   = v;
    endtask

    task automatic set_data(input logic [63:0] b, input logic [JW-1:0] ind,
                            input logic [J*AW-1:0] x, input logic [J*A*64-1:0] al);
        bus.backbone  = b;
        bus.ind_j     = ind;
        bus.x_initial = x;
        bus.alpha_u   = al;
    endtask

    // Returns just after edge E0 that captured all four operands.
    task automatic drive_all(input logic [63:0] b, input logic [JW-1:0] ind,
                             input logic [J*AW-1:0] x, input logic [J*A*64-1:0] al);
        @(posedge clk); #1;
        set_data(b, ind, x, al);
        set_tvalids(1'b1);
        @(posedge clk); #1;
        set_tvalids(1'b0);
    endtask

    task automatic wait_result(input string name, input logic [63:0] req);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        while (lat < 20) begin
            if (bus.vinput_tvalid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout: no vinput_tvalid within %0d cycles, expected latency 4", name, lat);
        end else begin
            check_int({name, ".lat"}, lat, 4);
            check64({name, ".val"}, bus.vinput, req);
            @(posedge clk); #1;
            check_int({name, ".pulse"}, int'(bus.vinput_tvalid), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [J*AW-1:0]   x;
        logic [J*A*64-1:0] al;
        logic [63:0]       alpha_arr[J*A];
        int                xent[J];
        int                seen;

        vecs[0]  = '{64'h3FF0_0000_0000_0000, 5'd7,  2'd1, 64'h402A_0000_0000_0000, 64'hC028_0000_0000_0000};
        vecs[1]  = '{64'h402A_0000_0000_0000, 5'd7,  2'd1, 64'h402A_0000_0000_0000, 64'h0000_0000_0000_0000};
        vecs[2]  = '{64'h3FF0_0000_0000_0001, 5'd2,  2'd0, 64'h3FF0_0000_0000_0000, 64'h3CB0_0000_0000_0000};
        vecs[3]  = '{64'h4009_21FB_5444_2D18, 5'd14, 2'd0, 64'h4000_0000_0000_0000, 64'h4009_21FB_5444_2D18};
        vecs[4]  = '{64'hC0FE_2400_0000_0000, 5'd3,  2'd3, 64'h4000_0000_0000_0000, 64'hC0FE_2400_0000_0000};
        vecs[5]  = '{64'h7FF0_0000_0000_0001, 5'd0,  2'd0, 64'h3FF0_0000_0000_0000, QNAN};
        vecs[6]  = '{64'h7FF0_0000_0000_0000, 5'd5,  2'd1, 64'h7FF0_0000_0000_0000, QNAN};
        vecs[7]  = '{64'h7FF0_0000_0000_0000, 5'd5,  2'd0, 64'h3FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000};
        vecs[8]  = '{64'h4340_0000_0000_0000, 5'd9,  2'd1, 64'hBFF0_0000_0000_0000, 64'h4340_0000_0000_0000};
        vecs[9]  = '{64'h4340_0000_0000_0001, 5'd9,  2'd0, 64'hBFF0_0000_0000_0000, 64'h4340_0000_0000_0002};
        vecs[10] = '{64'h3FF0_0000_0000_0000, 5'd13, 2'd1, 64'hFFF0_0000_0000_0000, 64'h7FF0_0000_0000_0000};
        vecs[11] = '{64'h0000_0000_0000_0005, 5'd1,  2'd1, 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000};
        vecs[12] = '{64'h7FEF_FFFF_FFFF_FFFF, 5'd4,  2'd0, 64'hFFEF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0000};
        vecs[13] = '{64'hFFF0_0000_0000_0000, 5'd6,  2'd1, 64'h3FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000};

        rst = 1'b1;
        set_data(64'd0, '0, '0, '0);
        set_tvalids(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check64("reset.vinput", bus.vinput, 64'd0);
        check_int("reset.tvalid", int'(bus.vinput_tvalid), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            int ji, xs;
            ji = int'(vecs[i].ind);
            xs = int'(vecs[i].xsel);
            x  = pattern_xi();
            al = pattern_alpha();
            if (ji < J) begin
                x[ji*AW +: AW] = vecs[i].xsel;
                if (xs < A) al[(ji*A + xs)*64 +: 64] = vecs[i].term;
            end
            drive_all(vecs[i].bb, vecs[i].ind, x, al);
            wait_result($sformatf("vec%0d", i), vecs[i].expv);
        end

        // Scrambled strobes: alpha, ind_j, x_initial, backbone on separate cycles
        begin
            int order[4];
            int gap[4];
            order = '{3, 2, 1, 0};
            gap   = '{1, 0, 2, 0};
            @(posedge clk); #1;
            set_data(64'h3FF0_0000_0000_0000, 5'd7, pattern_xi(), pattern_alpha());
            for (int s = 0; s < 4; s++) begin
                case (order[s])
                    0: bus.backbone_tvalid  = 1'b1;
                    1: bus.x_initial_tvalid = 1'b1;
                    2: bus.ind_j_tvalid     = 1'b1;
                    default: bus.alpha_u_tvalid = 1'b1;
                endcase
                @(posedge clk); #1;
                set_tvalids(1'b0);
                if (s < 3) begin
                    check_int($sformatf("scr.early%0d", s), int'(bus.vinput_tvalid), 0);
                    for (int g = 0; g < gap[s]; g++) begin
                        @(posedge clk); #1;
                        check_int($sformatf("scr.early%0d_%0d", s, g), int'(bus.vinput_tvalid), 0);
                    end
                end
            end
            wait_result("scrambled", 64'hC028_0000_0000_0000);
        end

        // Continuous strobes: one result every 5 cycles
        begin
            int first, second;
            first  = -1;
            second = -1;
            @(posedge clk); #1;
            set_data(64'h4014_0000_0000_0000, 5'd0, pattern_xi(), pattern_alpha());
            set_tvalids(1'b1);
            for (int c = 0; c < 30 && second < 0; c++) begin
                @(posedge clk); #1;
                if (bus.vinput_tvalid) begin
                    if (first < 0) first = c;
                    else second = c;
                    check64($sformatf("thru.val%0d", c), bus.vinput, 64'hC037_0000_0000_0000);
                end
            end
            set_tvalids(1'b0);
            check_int("thru.first_lat", first, 4);
            check_int("thru.period", second - first, 5);
            repeat (15) @(posedge clk);
        end

        // Random jobs against the reference
        for (int n = 0; n < 60; n++) begin
            logic [63:0]   bb, term;
            logic [JW-1:0] ind;
            bb  = rand_double(11'd1023);
            ind = JW'($urandom_range(0, 15));
            for (int k = 0; k < J*A; k++) begin
                if ($urandom_range(0, 3) == 0)
                    alpha_arr[k] = {1'($urandom_range(0, 1)), bb[62:8], 8'($urandom)};
                else
                    alpha_arr[k] = rand_double(bb[62:52]);
                al[k*64 +: 64] = alpha_arr[k];
            end
            for (int j = 0; j < J; j++) begin
                xent[j] = ($urandom_range(0, 7) < 7) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 3));
                x[j*AW +: AW] = AW'(xent[j]);
            end
            term = 64'd0;
            if (int'(ind) < J && xent[int'(ind)] < A) term = alpha_arr[int'(ind)*A + xent[int'(ind)]];
            drive_all(bb, ind, x, al);
            wait_result($sformatf("rnd%0d", n), model(bb, term));
        end

        // Reset two cycles after launch aborts the job
        drive_all(64'h3FF0_0000_0000_0000, 5'd7, pattern_xi(), pattern_alpha());
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.vinput_tvalid) seen++;
        end
        check_int("abort.no_pulse", seen, 0);
        check64("abort.vinput", bus.vinput, 64'd0);
        drive_all(64'h4014_0000_0000_0000, 5'd0, pattern_xi(), pattern_alpha());
        wait_result("after_abort", 64'hC037_0000_0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
